alu_accumulator: RTL and testbench
==================================

Name: alu_accumulator

Overview:
Sequencing and writeback stage wrapped around the combinational `alu`. It accepts one command (opcode plus operand) per valid/ready handshake and drives the ALU with a = accumulator, b = latched operand. It writes the ALU result back into the accumulator and keeps status flags. It is the register/control stage that feeds `alu` and consumes its result; `alu` itself stays purely combinational.

Parameters:
N, 8, datapath width; must equal the width of the instantiated `alu`.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_valid  in  1  command valid.
o_ready  out  1  block can accept a command this cycle.
i_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LOAD, 101-111 NOP.
i_operand  in  N  operand for the command.
o_alu_a  out  N  to alu a; always equals the accumulator register.
o_alu_b  out  N  to alu b; always equals the latched operand register.
o_alu_ctrl  out  2  to alu ctrl; always equals latched op[1:0].
i_alu_result  in  N  from alu result.
i_alu_carry_out  in  1  from alu carry_out.
o_acc  out  N  accumulator.
o_carry  out  1  carry flag.
o_zero  out  1  zero flag.
o_overflow  out  1  signed overflow flag (see Optional Feature).
o_done  out  1  one-cycle pulse: command retired.

Behaviour:
- Reset (i_reset=1 at an edge):
  - state IDLE; acc, operand register and op register = 0.
  - o_carry, o_zero, o_overflow, o_done = 0.
  - Reset wins over every other event, including a handshake in the same cycle and a command in EXEC; the pending command is discarded and no o_done pulse follows.
- FSM with two states, IDLE and EXEC.
  - IDLE: o_ready=1. On i_valid&&o_ready at edge E0, latch i_op and i_operand; go to EXEC.
  - EXEC: o_ready=0; i_valid is ignored and nothing is latched. ALU inputs are stable from registers for the whole cycle. At edge E1 perform the writeback below; go to IDLE; o_done=1 for the cycle after E1 only.
- Latency: accept at E0, acc/flags visible after E1, o_done high during the cycle following E1.
  - A new command may be accepted in that same done cycle.
  - Throughput: one command per 2 cycles.
- Writeback at E1:
  - ADD/SUB: acc<=i_alu_result; carry<=i_alu_carry_out; zero<=(i_alu_result==0); overflow per feature.
  - AND/OR: acc<=i_alu_result; zero updated; carry unchanged; overflow<=0.
  - LOAD: acc<=operand register (ALU output ignored); zero<=(operand==0); carry unchanged; overflow<=0.
  - NOP (101-111): acc and all flags unchanged; o_done still pulses.
- Width: all N-bit arithmetic wraps modulo 2^N, since the ALU result is N bits. The carry convention is whatever the ALU reports; this block does not reinterpret it.
- o_alu_* are continuous assignments from registers, so there is no combinational path from i_op/i_operand to the ALU.

Optional Feature:
- Macro: ALU_ACC_OVERFLOW_EN.
- Defined: on ADD/SUB, o_overflow is written with signed overflow, using a=acc, b=operand, r=i_alu_result:
  - ADD: a[N-1]==b[N-1] && r[N-1]!=a[N-1].
  - SUB: a[N-1]!=b[N-1] && r[N-1]!=a[N-1].
  - Cleared on AND/OR/LOAD, unchanged on NOP.
- Undefined: o_overflow is the constant 0; the port is still present and there is no overflow logic.

Test Plan:
(Bench instantiates alu_accumulator connected to `alu #(8)`, N=8.)
1. Reset for 2 cycles, release -> acc=0x00, carry=0, zero=0, overflow=0, done=0, ready=1; ready=0 exactly one cycle after each accept.
2. LOAD 0xBD then ADD 0xA5 -> after ADD done: acc=0x62, carry=1, zero=0; each done pulse is exactly 1 cycle, two cycles after its accept edge.
3. LOAD 0xBD, SUB 0xA5 -> acc=0x18, carry = ALU carry_out (1), zero=0. Then AND 0xA5 -> acc=0x00 (0x18&0xA5), zero=1, carry still 1.
4. LOAD 0xBD, OR 0xA5 -> acc=0xBD. Holding i_valid=1 with op=ADD 0x01 through EXEC -> only one command accepted per IDLE cycle; acc advances once per 2 cycles.
5. LOAD 0x7F, ADD 0x01 -> acc=0x80, carry=0, overflow=1 with ALU_ACC_OVERFLOW_EN and 0 without. NOP 0xFF -> acc and flags unchanged, done pulses.
6. LOAD 0x55, then ADD 0x01 with i_reset asserted during its EXEC cycle -> acc=0x00, all flags 0, no done pulse, ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : alu_accumulator
// Description : Handshaked command sequencer and writeback stage around a
//               combinational alu. Holds the accumulator and status flags.
//               Optional signed-overflow flag: define ALU_ACC_OVERFLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_accumulator #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [2:0]   i_op,
    input  logic [N-1:0] i_operand,
    output logic [N-1:0] o_alu_a,
    output logic [N-1:0] o_alu_b,
    output logic [1:0]   o_alu_ctrl,
    input  logic [N-1:0] i_alu_result,
    input  logic         i_alu_carry_out,
    output logic [N-1:0] o_acc,
    output logic         o_carry,
    output logic         o_zero,
    output logic         o_overflow,
    output logic         o_done
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_LOAD = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic         w_accept;
    logic [N-1:0] r_acc;
    logic [N-1:0] r_operand;
    logic [2:0]   r_op;
    logic         r_carry;
    logic         r_zero;
    logic         r_done;
    logic         w_res_zero;

    assign w_accept   = (r_state == ST_IDLE) && i_valid;
    assign w_res_zero = (i_alu_result == '0);

    // ALU is fed only from registers, so its inputs are stable for the whole EXEC cycle.
    assign o_alu_a    = r_acc;
    assign o_alu_b    = r_operand;
    assign o_alu_ctrl = r_op[1:0];
    assign o_ready    = (r_state == ST_IDLE);
    assign o_acc      = r_acc;
    assign o_carry    = r_carry;
    assign o_zero     = r_zero;
    assign o_done     = r_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_valid) w_state_next = ST_EXEC;
            ST_EXEC: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef ALU_ACC_OVERFLOW_EN
    logic r_overflow;
    logic w_ovf_add;
    logic w_ovf_sub;

    assign w_ovf_add  = (r_acc[N-1] == r_operand[N-1]) && (i_alu_result[N-1] != r_acc[N-1]);
    assign w_ovf_sub  = (r_acc[N-1] != r_operand[N-1]) && (i_alu_result[N-1] != r_acc[N-1]);
    assign o_overflow = r_overflow;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            case (r_op)
                c_OP_ADD:                     r_overflow <= w_ovf_add;
                c_OP_SUB:                     r_overflow <= w_ovf_sub;
                c_OP_AND, c_OP_OR, c_OP_LOAD: r_overflow <= 1'b0;
                default:                      r_overflow <= r_overflow;
            endcase
        end
    end
`else
    assign o_overflow = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_operand <= '0;
            r_op      <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_op      <= i_op;
                r_operand <= i_operand;
            end
            if (r_state == ST_EXEC) begin
                r_done <= 1'b1;
                case (r_op)
                    c_OP_ADD, c_OP_SUB: begin
                        r_acc   <= i_alu_result;
                        r_carry <= i_alu_carry_out;
                        r_zero  <= w_res_zero;
                    end
                    c_OP_AND, c_OP_OR: begin
                        r_acc  <= i_alu_result;
                        r_zero <= w_res_zero;
                    end
                    // LOAD bypasses the ALU entirely.
                    c_OP_LOAD: begin
                        r_acc  <= r_operand;
                        r_zero <= (r_operand == '0);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_accumulator
// Description : Scoreboard bench for alu_accumulator with a behavioural alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_accumulator;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic         ready;
    logic [2:0]   op;
    logic [N-1:0] operand;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic [N-1:0] alu_result;
    logic         alu_carry;
    logic [N-1:0] acc;
    logic         carry;
    logic         zero;
    logic         overflow;
    logic         done;

    typedef struct packed {
        logic [N-1:0] acc;
        logic         carry;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef ALU_ACC_OVERFLOW_EN
    localparam bit c_OVF = 1'b1;
`else
    localparam bit c_OVF = 1'b0;
`endif

    always #5 clk = ~clk;

    // Behavioural alu: carry is the carry-out of a + b or a + ~b + 1.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (alu_ctrl)
            2'b00: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            2'b10: alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    alu_accumulator #(.N(N)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_valid         (valid),
        .o_ready         (ready),
        .i_op            (op),
        .i_operand       (operand),
        .o_alu_a         (alu_a),
        .o_alu_b         (alu_b),
        .o_alu_ctrl      (alu_ctrl),
        .i_alu_result    (alu_result),
        .i_alu_carry_out (alu_carry),
        .o_acc           (acc),
        .o_carry         (carry),
        .o_zero          (zero),
        .o_overflow      (overflow),
        .o_done          (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse retires exactly one queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending command");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_acc", {24'd0, acc}, {24'd0, e.acc});
                check("sb_carry", {31'd0, carry}, {31'd0, e.carry});
                check("sb_zero", {31'd0, zero}, {31'd0, e.zero});
                check("sb_ovf", {31'd0, overflow}, {31'd0, e.ovf});
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got ready=%b expected 1", ready);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [N-1:0] d,
                         input logic [N-1:0] ea, input logic ec, input logic ez, input logic eo);
        wait_ready();
        valid   = 1'b1;
        op      = o;
        operand = d;
        exp_q.push_back('{acc: ea, carry: ec, zero: ez, ovf: eo});
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("ready_low_exec", {31'd0, ready}, 32'd0);
        check("done_low_exec", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("ready_in_done", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; op = '0; operand = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_acc", {24'd0, acc}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);

        issue(3'b100, 8'hBD, 8'hBD, 1'b0, 1'b0, 1'b0);
        issue(3'b000, 8'hA5, 8'h62, 1'b1, 1'b0, c_OVF);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);

        issue(3'b100, 8'hBD, 8'hBD, 1'b1, 1'b0, 1'b0);
        issue(3'b001, 8'hA5, 8'h18, 1'b1, 1'b0, 1'b0);
        issue(3'b010, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0);

        issue(3'b100, 8'hBD, 8'hBD, 1'b1, 1'b0, 1'b0);
        issue(3'b011, 8'hA5, 8'hBD, 1'b1, 1'b0, 1'b0);

        // Hold valid through EXEC: accepts only on IDLE edges.
        wait_ready();
        valid = 1'b1; op = 3'b000; operand = 8'h01;
        exp_q.push_back('{acc: 8'hBE, carry: 1'b0, zero: 1'b0, ovf: 1'b0});
        exp_q.push_back('{acc: 8'hBF, carry: 1'b0, zero: 1'b0, ovf: 1'b0});
        exp_q.push_back('{acc: 8'hC0, carry: 1'b0, zero: 1'b0, ovf: 1'b0});
        repeat (2) @(posedge clk);
        #1;
        check("hold_acc_1", {24'd0, acc}, 32'h0BE);
        @(posedge clk); #1;
        check("hold_acc_stays", {24'd0, acc}, 32'h0BE);
        check("hold_ready_low", {31'd0, ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        valid = 1'b0;
        check("hold_acc_3", {24'd0, acc}, 32'h0C0);
        @(posedge clk); #1;
        check("hold_no_4th", {31'd0, ready}, 32'd1);

        issue(3'b100, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0);
        issue(3'b000, 8'h01, 8'h80, 1'b0, 1'b0, c_OVF);
        issue(3'b101, 8'hFF, 8'h80, 1'b0, 1'b0, c_OVF);

        // Reset during EXEC discards the command.
        issue(3'b100, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_ready();
        valid = 1'b1; op = 3'b000; operand = 8'h01;
        @(posedge clk);
        #1;
        valid = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rr_acc", {24'd0, acc}, 32'd0);
        check("rr_carry", {31'd0, carry}, 32'd0);
        check("rr_zero", {31'd0, zero}, 32'd0);
        check("rr_ovf", {31'd0, overflow}, 32'd0);
        check("rr_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("rr_done_after", {31'd0, done}, 32'd0);
        check("rr_ready_after", {31'd0, ready}, 32'd1);
        repeat (2) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
